// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and the external data memory (slave).
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage controller: req/ack data-memory access with stall, branch
// resolve, ack watchdog; MEM_ALIGN_CHECK_EN enables the alignment fault.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         Branch,
    input  logic         zero,
    input  logic [31:0]  total_alu,
    input  logic [31:0]  rd2,
    mem_access_if.master mem,
    output logic         stall,
    output logic         PCSrc,
    output logic [31:0]  rdata_out,
    output logic         err_timeout,
    output logic         err_misalign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;
    logic        mis_q, mis_d;
    logic        memop;
    logic        req;
    logic        misaligned;

    assign memop = MemRead | MemWrite;
    assign PCSrc = Branch & zero;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (total_alu[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        mis_d   = mis_q;
        stall   = 1'b0;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    stall   = 1'b1;
                    addr_d  = total_alu;
                    wdata_d = rd2;
                    we_d    = MemWrite;
                    cnt_d   = 8'd0;
                    if (misaligned) begin
                        // Faulting access never reaches memory.
                        mis_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                req   = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            tmo_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            mis_q   <= mis_d;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata_out     = rdata_q;
    assign err_timeout   = tmo_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign err_misalign = mis_q;
`else
    assign err_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (ACK_TIMEOUT=4); alignment scenario
// follows MEM_ALIGN_CHECK_EN.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        zero;
    logic [31:0] total_alu;
    logic [31:0] rd2;
    logic        stall;
    logic        PCSrc;
    logic [31:0] rdata_out;
    logic        err_timeout;
    logic        err_misalign;

    int vecs = 0;
    int errs = 0;

    mem_access_if mif ();

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .zero         (zero),
        .total_alu    (total_alu),
        .rd2          (rd2),
        .mem          (mif),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .rdata_out    (rdata_out),
        .err_timeout  (err_timeout),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one memop and acknowledges it on the ack_at-th request cycle
    // (0 = never); returns observed counts and bus values.
    task automatic drive_op(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  int          ack_at,
        input  logic [31:0] rdv,
        output int          n_stall,
        output int          n_req,
        output logic [31:0] a_seen,
        output logic [31:0] w_seen,
        output logic        we_seen,
        output bit          stable,
        output bit          done
    );
        n_stall = 0;
        n_req   = 0;
        a_seen  = '0;
        w_seen  = '0;
        we_seen = 1'b0;
        stable  = 1'b1;
        done    = 1'b0;
        @(negedge clk);
        MemRead = rd;
        MemWrite = wr;
        total_alu = addr;
        rd2 = wd;
        mif.mem_ack = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (stall) n_stall++;
            if (mif.mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    a_seen  = mif.mem_addr;
                    w_seen  = mif.mem_wdata;
                    we_seen = mif.mem_we;
                end else if (mif.mem_addr !== a_seen ||
                             mif.mem_wdata !== w_seen ||
                             mif.mem_we !== we_seen) begin
                    stable = 1'b0;
                end
            end
            if (!stall && cyc > 0) begin
                done = 1'b1;
                MemRead = 1'b0;
                MemWrite = 1'b0;
                mif.mem_ack = 1'b0;
                break;
            end
            mif.mem_ack = (ack_at > 0 && n_req == ack_at);
            mif.mem_rdata = rdv;
            @(negedge clk);
        end
        if (!done) begin
            MemRead = 1'b0;
            MemWrite = 1'b0;
            mif.mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Branch = 1'b0;
        zero = 1'b0;
        total_alu = '0;
        rd2 = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if ({mif.mem_req, mif.mem_we, stall, err_timeout, err_misalign}
            !== 5'b0) begin
            $display("FAIL reset_ctl: got %b want 00000",
                {mif.mem_req, mif.mem_we, stall, err_timeout, err_misalign});
            errs++;
        end
        vecs++;
        if ({mif.mem_addr, mif.mem_wdata, rdata_out} !== 96'd0) begin
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
                mif.mem_addr, mif.mem_wdata, rdata_out);
            errs++;
        end
    endtask

    task automatic test_load();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        drive_op(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (!dn) begin
            $display("FAIL load_done: got stuck want DONE");
            errs++;
        end
        vecs++;
        if (nr !== 3) begin
            $display("FAIL load_req: got %0d want 3", nr);
            errs++;
        end
        vecs++;
        if (ns !== 4) begin
            $display("FAIL load_stall: got %0d want 4", ns);
            errs++;
        end
        vecs++;
        if (we !== 1'b0 || a !== 32'h100 || !st) begin
            $display("FAIL load_bus: we %b addr %h stable %0d want 0 100 1",
                we, a, st);
            errs++;
        end
        vecs++;
        if (rdata_out !== 32'hCAFEF00D) begin
            $display("FAIL load_rdata: got %h want cafef00d", rdata_out);
            errs++;
        end
    endtask

    task automatic test_store();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        drive_op(1'b0, 1'b1, 32'h20, 32'h12345678, 1, 32'hFFFFFFFF,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (!dn || nr !== 1 || ns !== 2) begin
            $display("FAIL store_cnt: done %0d req %0d stall %0d want 1 1 2",
                dn, nr, ns);
            errs++;
        end
        vecs++;
        if (we !== 1'b1 || a !== 32'h20 || w !== 32'h12345678) begin
            $display("FAIL store_bus: we %b addr %h wdata %h want 1 20 12345678",
                we, a, w);
            errs++;
        end
        vecs++;
        if (rdata_out !== 32'hCAFEF00D) begin
            $display("FAIL store_rdata: got %h want cafef00d", rdata_out);
            errs++;
        end
    endtask

    task automatic test_both_set();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        drive_op(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 2, 32'h77777777,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (we !== 1'b1 || nr !== 2 || rdata_out !== 32'hCAFEF00D) begin
            $display("FAIL both_write: we %b req %0d rdata %h want 1 2 cafef00d",
                we, nr, rdata_out);
            errs++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        MemRead = 1'b1;
        total_alu = 32'h80;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if (mif.mem_req !== 1'b1) begin
            $display("FAIL rstmid_pre: req %b want 1", mif.mem_req);
            errs++;
        end
        rst = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        #1;
        vecs++;
        if ({mif.mem_req, mif.mem_we, stall} !== 3'b0 ||
            {mif.mem_addr, mif.mem_wdata, rdata_out} !== 96'd0) begin
            $display("FAIL rstmid_out: req %b we %b stall %b addr %h rdata %h want 0",
                mif.mem_req, mif.mem_we, stall, mif.mem_addr, rdata_out);
            errs++;
        end
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        vecs++;
        if (rdata_out !== 32'd0 || mif.mem_req !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL rstmid_lateack: rdata %h req %b stall %b want 0 0 0",
                rdata_out, mif.mem_req, stall);
            errs++;
        end
    endtask

    task automatic test_timeout();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        drive_op(1'b1, 1'b0, 32'h30, 32'h0, 2, 32'h11223344,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (rdata_out !== 32'h11223344) begin
            $display("FAIL tmo_pre: rdata %h want 11223344", rdata_out);
            errs++;
        end
        drive_op(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (!dn || nr !== 4 || ns !== 5) begin
            $display("FAIL tmo_cnt: done %0d req %0d stall %0d want 1 4 5",
                dn, nr, ns);
            errs++;
        end
        vecs++;
        if (err_timeout !== 1'b1 || rdata_out !== 32'd0) begin
            $display("FAIL tmo_err: err %b rdata %h want 1 0",
                err_timeout, rdata_out);
            errs++;
        end
        @(negedge clk);
        #1;
        vecs++;
        if (stall !== 1'b0 || mif.mem_req !== 1'b0 || err_timeout !== 1'b1) begin
            $display("FAIL tmo_idle: stall %b req %b err %b want 0 0 1",
                stall, mif.mem_req, err_timeout);
            errs++;
        end
    endtask

    task automatic test_ack_last();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        do_reset();
        drive_op(1'b1, 1'b0, 32'h50, 32'h0, 4, 32'h0BADF00D,
                 ns, nr, a, w, we, st, dn);
        vecs++;
        if (!dn || nr !== 4 || ns !== 5) begin
            $display("FAIL acklast_cnt: done %0d req %0d stall %0d want 1 4 5",
                dn, nr, ns);
            errs++;
        end
        vecs++;
        if (err_timeout !== 1'b0 || rdata_out !== 32'h0BADF00D) begin
            $display("FAIL acklast_err: err %b rdata %h want 0 0badf00d",
                err_timeout, rdata_out);
            errs++;
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        Branch = 1'b1;
        zero = 1'b1;
        #1;
        vecs++;
        if (PCSrc !== 1'b1 || stall !== 1'b0) begin
            $display("FAIL branch_taken: pcsrc %b stall %b want 1 0",
                PCSrc, stall);
            errs++;
        end
        zero = 1'b0;
        #1;
        vecs++;
        if (PCSrc !== 1'b0) begin
            $display("FAIL branch_nz: pcsrc %b want 0", PCSrc);
            errs++;
        end
        Branch = 1'b0;
        zero = 1'b1;
        #1;
        vecs++;
        if (PCSrc !== 1'b0) begin
            $display("FAIL branch_nobr: pcsrc %b want 0", PCSrc);
            errs++;
        end
        zero = 1'b0;
    endtask

    task automatic test_align();
        int ns, nr;
        logic [31:0] a, w;
        logic we;
        bit st, dn;
        drive_op(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h55555555,
                 ns, nr, a, w, we, st, dn);
`ifdef MEM_ALIGN_CHECK_EN
        vecs++;
        if (!dn || nr !== 0 || ns !== 1) begin
            $display("FAIL align_cnt: done %0d req %0d stall %0d want 1 0 1",
                dn, nr, ns);
            errs++;
        end
        vecs++;
        if (err_misalign !== 1'b1 || rdata_out !== 32'd0) begin
            $display("FAIL align_err: err %b rdata %h want 1 0",
                err_misalign, rdata_out);
            errs++;
        end
`else
        vecs++;
        if (!dn || nr !== 1 || ns !== 2 || a !== 32'h102) begin
            $display("FAIL align_off: done %0d req %0d stall %0d addr %h want 1 1 2 102",
                dn, nr, ns, a);
            errs++;
        end
        vecs++;
        if (err_misalign !== 1'b0 || rdata_out !== 32'h55555555) begin
            $display("FAIL align_off_err: err %b rdata %h want 0 55555555",
                err_misalign, rdata_out);
            errs++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_both_set();
        test_reset_mid();
        test_timeout();
        test_ack_last();
        test_branch();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
